// File: rtl/spart_rx_if.sv
// Bus-side view of the SPART receive buffer: read strobe in, byte and status out.
interface spart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 rx_read;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 framing_err;
  logic                 overrun;

  modport master (
    output rx_read,
    input  rx_data,
    input  rda,
    input  framing_err,
    input  overrun
  );

  modport slave (
    input  rx_read,
    output rx_data,
    output rda,
    output framing_err,
    output overrun
  );
endinterface

// File: rtl/spart_rx.sv
// SPART 8N1 receiver: synchronises rxd, re-phases the baud generator on a start edge,
// shifts data LSB first and holds the last good byte with rda/framing/overrun status.
module spart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rxd,
  input  logic         receive_baud,
  output logic         receive_start,
  spart_rx_if.slave    bus
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s, rxd_d;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   rda_q, framing_err_q, overrun_q;
  logic                   start_det, cnt_clr, shift_en, byte_good, byte_bad;

  // Stage: rxd synchroniser and edge-detect delay (idle-high reset avoids a false start)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      rxd_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxd_d  <= rxd_s;
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // Stage: frame FSM, decisions taken only on receive_baud outside IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    byte_good = 1'b0;
    byte_bad  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxd_d && !rxd_s) begin
          start_det = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (receive_baud) begin
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            cnt_clr = 1'b1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (receive_baud) begin
          shift_en = 1'b1;
          if (bit_cnt_q == LAST_CNT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (receive_baud) begin
          state_d   = IDLE;
          byte_good = rxd_s;
          byte_bad  = !rxd_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      receive_start <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
    end else begin
      receive_start <= start_det;
      if (cnt_clr) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      if (shift_en) begin
        shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
      end
    end
  end

  // Stage: holding register and status; a completing frame takes priority over rx_read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q     <= '0;
      rda_q         <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (byte_good) begin
        rx_data_q <= shift_q;
        rda_q     <= 1'b1;
      end else if (bus.rx_read) begin
        rda_q     <= 1'b0;
      end

      if (byte_bad) begin
        framing_err_q <= 1'b1;
      end else if (bus.rx_read) begin
        framing_err_q <= 1'b0;
      end

      if (bus.rx_read) begin
        overrun_q <= 1'b0;
      end else if (byte_good && rda_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rda         = rda_q;
  assign bus.framing_err = framing_err_q;
  assign bus.overrun     = overrun_q;

endmodule
